// File: rtl/fifo_cdc_pkg.sv
// Shared asynchronous-FIFO definitions: write-controller state encoding and Gray-code helpers.
// The helpers take zero-extended operands, so any pointer width up to GRAY_MAX_W converts correctly.
package fifo_cdc_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } wr_state_t;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        for (int i = 1; i < GRAY_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_burst_ctrl_gray_to_bin.sv
// Combinational Gray-to-binary conversion of the synchronized read pointer.
module gray_to_bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/fifo_wr_burst_ctrl.sv
// Write-domain burst controller for the async FIFO: admits whole bursts only when space exists.
// Optional macro WR_CTRL_FILL_LEVEL_EN adds the registered fill-level output W_Fill.
module fifo_wr_burst_ctrl
    import fifo_cdc_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  W_CLK,
    input  logic                  W_RST,
    input  logic [ADDR_WIDTH:0]   Wq2_rptr,
    input  logic                  Burst_Req,
    input  logic [ADDR_WIDTH:0]   Burst_Len,
    input  logic                  W_Data_Valid,
    output logic                  Burst_Gnt,
    output logic                  Burst_Err,
    output logic                  Burst_Done,
    output logic                  W_Ready,
    output logic                  W_En,
    output logic [ADDR_WIDTH-1:0] W_Addr,
    output logic [ADDR_WIDTH:0]   W_ptr,
    output logic                  W_Full
`ifdef WR_CTRL_FILL_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   W_Fill
`endif
);

    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_P = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_P   = (ADDR_WIDTH+1)'(1);

    wr_state_t             state_q, state_d;
    logic [ADDR_WIDTH:0]   wbin_q, wbin_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [ADDR_WIDTH:0]   rbin, used, free;
    logic                  gnt_d, err_d, done_d, full_d, len_bad;
    logic [GRAY_MAX_W-1:0] gray_next;

    gray_to_bin #(.W(ADDR_WIDTH+1)) u_rptr_g2b (
        .gray (Wq2_rptr),
        .bin  (rbin)
    );

    // Pointer difference modulo 2**(ADDR_WIDTH+1) is the occupancy; a stale rptr only overstates it.
    assign used    = wbin_q - rbin;
    assign free    = DEPTH_P - used;
    assign len_bad = (Burst_Len == '0) || (Burst_Len > DEPTH_P);

    assign W_Ready = (state_q == ST_BURST);
    assign W_En    = W_Data_Valid & W_Ready;
    assign W_Addr  = wbin_q[ADDR_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        wbin_d  = wbin_q;
        rem_d   = rem_q;
        gnt_d   = 1'b0;
        err_d   = 1'b0;
        done_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (Burst_Req) begin
                if (len_bad) begin
                    err_d = 1'b1;
                end else if (free >= Burst_Len) begin
                    state_d = ST_BURST;
                    rem_d   = Burst_Len;
                    gnt_d   = 1'b1;
                end
            end
        end else if (W_Data_Valid) begin
            wbin_d = wbin_q + ONE_P;
            rem_d  = rem_q - ONE_P;
            if (rem_q == ONE_P) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
        // Full when the next write pointer equals the read pointer with its top two Gray bits inverted.
        gray_next = bin2gray(GRAY_MAX_W'(wbin_d));
        full_d    = (gray_next == GRAY_MAX_W'({~Wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1],
                                                Wq2_rptr[ADDR_WIDTH-2:0]}));
    end

    always_ff @(posedge W_CLK or posedge W_RST) begin
        if (W_RST) begin
            state_q    <= ST_IDLE;
            wbin_q     <= '0;
            rem_q      <= '0;
            W_ptr      <= '0;
            W_Full     <= 1'b0;
            Burst_Gnt  <= 1'b0;
            Burst_Err  <= 1'b0;
            Burst_Done <= 1'b0;
        end else begin
            state_q    <= state_d;
            wbin_q     <= wbin_d;
            rem_q      <= rem_d;
            W_ptr      <= gray_next[ADDR_WIDTH:0];
            W_Full     <= full_d;
            Burst_Gnt  <= gnt_d;
            Burst_Err  <= err_d;
            Burst_Done <= done_d;
        end
    end

`ifdef WR_CTRL_FILL_LEVEL_EN
    always_ff @(posedge W_CLK or posedge W_RST) begin
        if (W_RST) begin
            W_Fill <= '0;
        end else begin
            W_Fill <= used;
        end
    end
`endif

endmodule
